// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit bundle: register addresses, valids and LL events in,
// stall/flush/forward-select and scoreboard status out.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W     = 5,
    parameter int NUM_FWD_STAGES = 2
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

    logic [NUM_FWD_STAGES-1:0]            FWD_reg_write;
    logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] FWD_rd;
    logic [REG_ADDR_W-1:0]                EXEC_rs1;
    logic [REG_ADDR_W-1:0]                EXEC_rs2;
    logic [SEL_W-1:0]                     FWD_rs1;
    logic [SEL_W-1:0]                     FWD_rs2;
    logic [REG_ADDR_W-1:0]                FETCH_rs1;
    logic [REG_ADDR_W-1:0]                FETCH_rs2;
    logic                                 FETCH_use_rs1;
    logic                                 FETCH_use_rs2;
    logic [REG_ADDR_W-1:0]                FETCH_rd;
    logic                                 FETCH_ll;
    logic                                 FETCH_valid;
    logic                                 MEM_valid;
    logic                                 EXEC_mem_read;
    logic [REG_ADDR_W-1:0]                EXEC_rd;
    logic                                 BRA;
    logic                                 JMP;
    logic                                 LL_issue;
    logic [REG_ADDR_W-1:0]                LL_issue_rd;
    logic                                 LL_done;
    logic [REG_ADDR_W-1:0]                LL_done_rd;
    logic                                 FETCH_stall;
    logic                                 EXEC_stall;
    logic                                 EXEC_flush;
    logic                                 MEM_flush;
    logic                                 LL_busy;
    logic                                 SB_err;

    // Pipeline side: drives register/valid/event information.
    modport master (
        output FWD_reg_write, FWD_rd, EXEC_rs1, EXEC_rs2,
        output FETCH_rs1, FETCH_rs2, FETCH_use_rs1, FETCH_use_rs2, FETCH_rd, FETCH_ll,
        output FETCH_valid, MEM_valid, EXEC_mem_read, EXEC_rd, BRA, JMP,
        output LL_issue, LL_issue_rd, LL_done, LL_done_rd,
        input  FWD_rs1, FWD_rs2, FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush,
        input  LL_busy, SB_err
    );

    // Hazard unit side.
    modport slave (
        input  FWD_reg_write, FWD_rd, EXEC_rs1, EXEC_rs2,
        input  FETCH_rs1, FETCH_rs2, FETCH_use_rs1, FETCH_use_rs2, FETCH_rd, FETCH_ll,
        input  FETCH_valid, MEM_valid, EXEC_mem_read, EXEC_rd, BRA, JMP,
        input  LL_issue, LL_issue_rd, LL_done, LL_done_rd,
        output FWD_rs1, FWD_rs2, FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush,
        output LL_busy, SB_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit: operand forwarding select, load-use and long-latency scoreboard stalls,
// and a multi-cycle branch/jump flush shadow.
module hazard_scoreboard #(
    parameter int REG_ADDR_W      = 5,
    parameter int NUM_FWD_STAGES  = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave hz
);
    localparam int SEL_W    = $clog2(NUM_FWD_STAGES + 1);
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int SH_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [SH_W-1:0]       SH_RELOAD = SH_W'(FLUSH_CYCLES - 1);
    localparam logic [SH_W-1:0]       SH_ONE    = SH_W'(1);

    // Youngest matching writer wins, so scan from oldest to youngest and let later hits override.
    function automatic logic [SEL_W-1:0] fwd_select(
        input logic [REG_ADDR_W-1:0]                src,
        input logic [NUM_FWD_STAGES-1:0]            wr,
        input logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] rd
    );
        logic [SEL_W-1:0] sel;
        sel = {SEL_W{1'b0}};
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if ((src != REG_ZERO) && wr[k] && (rd[k*REG_ADDR_W +: REG_ADDR_W] == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
        return sel;
    endfunction

    logic [NUM_REGS-1:0] pending_r;
    logic [CNT_W-1:0]    count_r;
    logic [SH_W-1:0]     shadow_r;
    logic                sb_err_r;

    logic [NUM_REGS-1:0] pending_next_s;
    logic [CNT_W-1:0]    count_next_s;
    logic [SH_W-1:0]     shadow_next_s;
    logic                sb_err_next_s;

    logic                ll_busy_s;
    logic                src1_haz_s;
    logic                src2_haz_s;
    logic                dst_haz_s;
    logic                load_stall_s;
    logic                sb_stall_s;
    logic                exec_stall_s;
    logic                fetch_stall_s;
    logic                exec_flush_s;
    logic                issue_v_s;
    logic                issue_ok_s;
    logic                overflow_s;
    logic                done_v_s;
    logic                done_bad_s;
    logic [SEL_W-1:0]    fwd_rs1_s;
    logic [SEL_W-1:0]    fwd_rs2_s;

    assign ll_busy_s = (count_r == CNT_MAX);

    // Forwarding selects and stall/flush decode.
    always_comb begin
        fwd_rs1_s     = fwd_select(hz.EXEC_rs1, hz.FWD_reg_write, hz.FWD_rd);
        fwd_rs2_s     = fwd_select(hz.EXEC_rs2, hz.FWD_reg_write, hz.FWD_rd);
        src1_haz_s    = hz.FETCH_use_rs1 && (hz.FETCH_rs1 != REG_ZERO);
        src2_haz_s    = hz.FETCH_use_rs2 && (hz.FETCH_rs2 != REG_ZERO);
        dst_haz_s     = hz.FETCH_ll && (hz.FETCH_rd != REG_ZERO);
        load_stall_s  = hz.EXEC_mem_read && (hz.EXEC_rd != REG_ZERO) &&
                        ((src1_haz_s && (hz.FETCH_rs1 == hz.EXEC_rd)) ||
                         (src2_haz_s && (hz.FETCH_rs2 == hz.EXEC_rd)));
        // Scoreboard is read from the register only: a done this cycle releases next cycle.
        sb_stall_s    = (src1_haz_s && pending_r[hz.FETCH_rs1]) ||
                        (src2_haz_s && pending_r[hz.FETCH_rs2]) ||
                        (dst_haz_s  && pending_r[hz.FETCH_rd])  ||
                        (hz.FETCH_ll && ll_busy_s);
        exec_stall_s  = ~hz.MEM_valid;
        fetch_stall_s = ~hz.FETCH_valid || exec_stall_s || load_stall_s || sb_stall_s;
        exec_flush_s  = hz.BRA || hz.JMP || (shadow_r != {SH_W{1'b0}}) || fetch_stall_s;
    end

    // Scoreboard, outstanding count, error and flush-shadow next state.
    always_comb begin
        pending_next_s = pending_r;
        count_next_s   = count_r;
        shadow_next_s  = shadow_r;
        sb_err_next_s  = sb_err_r;

        issue_v_s  = hz.LL_issue && (hz.LL_issue_rd != REG_ZERO);
        done_v_s   = hz.LL_done && (hz.LL_done_rd != REG_ZERO) && pending_r[hz.LL_done_rd];
        done_bad_s = hz.LL_done && (hz.LL_done_rd != REG_ZERO) && !pending_r[hz.LL_done_rd];
        // A simultaneous valid done frees a slot, so only an unpaired issue at full overflows.
        overflow_s = issue_v_s && !done_v_s && ll_busy_s;
        issue_ok_s = issue_v_s && !overflow_s;

        if (done_v_s) begin
            pending_next_s[hz.LL_done_rd] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (issue_ok_s) begin
            pending_next_s[hz.LL_issue_rd] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end

        case ({issue_ok_s, done_v_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        if (overflow_s || done_bad_s) begin
            sb_err_next_s = 1'b1;
        end else begin
            sb_err_next_s = sb_err_r;
        end

        if (hz.BRA || hz.JMP) begin
            shadow_next_s = SH_RELOAD;
        end else if (shadow_r != {SH_W{1'b0}}) begin
            shadow_next_s = shadow_r - SH_ONE;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // State registers; reset drops all in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NUM_REGS{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            shadow_r  <= {SH_W{1'b0}};
            sb_err_r  <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            count_r   <= count_next_s;
            shadow_r  <= shadow_next_s;
            sb_err_r  <= sb_err_next_s;
        end
    end

    assign hz.FWD_rs1     = fwd_rs1_s;
    assign hz.FWD_rs2     = fwd_rs2_s;
    assign hz.FETCH_stall = fetch_stall_s;
    assign hz.EXEC_stall  = exec_stall_s;
    assign hz.MEM_flush   = exec_stall_s;
    assign hz.EXEC_flush  = exec_flush_s;
    assign hz.LL_busy     = ll_busy_s;
    assign hz.SB_err      = sb_err_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MAX_OUTSTANDING=4, FLUSH_CYCLES=3).
module tb_hazard_scoreboard;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.REG_ADDR_W(5), .NUM_FWD_STAGES(2)) hz ();

    hazard_scoreboard #(
        .REG_ADDR_W(5), .NUM_FWD_STAGES(2), .MAX_OUTSTANDING(4), .FLUSH_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        hz.FWD_reg_write = 2'b00;
        hz.FWD_rd        = 10'd0;
        hz.EXEC_rs1      = 5'd0;
        hz.EXEC_rs2      = 5'd0;
        hz.FETCH_rs1     = 5'd0;
        hz.FETCH_rs2     = 5'd0;
        hz.FETCH_use_rs1 = 1'b0;
        hz.FETCH_use_rs2 = 1'b0;
        hz.FETCH_rd      = 5'd0;
        hz.FETCH_ll      = 1'b0;
        hz.FETCH_valid   = 1'b1;
        hz.MEM_valid     = 1'b1;
        hz.EXEC_mem_read = 1'b0;
        hz.EXEC_rd       = 5'd0;
        hz.BRA           = 1'b0;
        hz.JMP           = 1'b0;
        hz.LL_issue      = 1'b0;
        hz.LL_issue_rd   = 5'd0;
        hz.LL_done       = 1'b0;
        hz.LL_done_rd    = 5'd0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_ll_busy", 32'(hz.LL_busy), 32'd0);
        chk("rst_sb_err", 32'(hz.SB_err), 32'd0);
        chk("rst_fetch_stall", 32'(hz.FETCH_stall), 32'd0);
        chk("rst_exec_flush", 32'(hz.EXEC_flush), 32'd0);
        rst_n = 1'b1;
        tick();

        // Forwarding: stage1=WB, stage0=MEM
        hz.FWD_reg_write = 2'b11;
        hz.FWD_rd = {5'd5, 5'd5};
        hz.EXEC_rs1 = 5'd5;
        #1 chk("fwd_both", 32'(hz.FWD_rs1), 32'd1);
        hz.FWD_reg_write = 2'b10;
        #1 chk("fwd_wb_only", 32'(hz.FWD_rs1), 32'd2);
        hz.FWD_reg_write = 2'b11;
        hz.FWD_rd = {5'd0, 5'd0};
        hz.EXEC_rs1 = 5'd0;
        #1 chk("fwd_x0", 32'(hz.FWD_rs1), 32'd0);
        hz.FWD_rd = {5'd6, 5'd5};
        hz.EXEC_rs2 = 5'd6;
        #1 chk("fwd_rs2_wb", 32'(hz.FWD_rs2), 32'd2);
        hz.EXEC_rs2 = 5'd3;
        #1 chk("fwd_rs2_none", 32'(hz.FWD_rs2), 32'd0);
        hz.FWD_reg_write = 2'b00;
        hz.EXEC_rs2 = 5'd0;

        // Load-use
        hz.EXEC_mem_read = 1'b1;
        hz.EXEC_rd = 5'd7;
        hz.FETCH_rs2 = 5'd7;
        hz.FETCH_use_rs2 = 1'b1;
        #1 chk("lu_stall", 32'(hz.FETCH_stall), 32'd1);
        chk("lu_flush", 32'(hz.EXEC_flush), 32'd1);
        hz.FETCH_use_rs2 = 1'b0;
        #1 chk("lu_nouse_stall", 32'(hz.FETCH_stall), 32'd0);
        chk("lu_nouse_flush", 32'(hz.EXEC_flush), 32'd0);
        hz.EXEC_mem_read = 1'b0;
        hz.EXEC_rd = 5'd0;
        hz.FETCH_rs2 = 5'd0;

        // Valid-driven stalls
        hz.MEM_valid = 1'b0;
        #1 chk("memv_exec_stall", 32'(hz.EXEC_stall), 32'd1);
        chk("memv_mem_flush", 32'(hz.MEM_flush), 32'd1);
        chk("memv_fetch_stall", 32'(hz.FETCH_stall), 32'd1);
        hz.MEM_valid = 1'b1;
        hz.FETCH_valid = 1'b0;
        #1 chk("fv_fetch_stall", 32'(hz.FETCH_stall), 32'd1);
        chk("fv_exec_stall", 32'(hz.EXEC_stall), 32'd0);
        hz.FETCH_valid = 1'b1;

        // LL RAW/WAW on x9
        hz.LL_issue = 1'b1;
        hz.LL_issue_rd = 5'd9;
        tick();
        hz.LL_issue = 1'b0;
        hz.FETCH_rs1 = 5'd9;
        hz.FETCH_use_rs1 = 1'b1;
        #1 chk("ll_raw_c1", 32'(hz.FETCH_stall), 32'd1);
        tick();
        #1 chk("ll_raw_c2", 32'(hz.FETCH_stall), 32'd1);
        hz.FETCH_use_rs1 = 1'b0;
        hz.FETCH_ll = 1'b1;
        hz.FETCH_rd = 5'd9;
        #1 chk("ll_waw", 32'(hz.FETCH_stall), 32'd1);
        hz.FETCH_ll = 1'b0;
        hz.FETCH_rd = 5'd0;
        hz.FETCH_use_rs1 = 1'b1;
        hz.LL_done = 1'b1;
        hz.LL_done_rd = 5'd9;
        #1 chk("ll_done_same_cycle", 32'(hz.FETCH_stall), 32'd1);
        tick();
        hz.LL_done = 1'b0;
        #1 chk("ll_released", 32'(hz.FETCH_stall), 32'd0);
        chk("ll_no_err", 32'(hz.SB_err), 32'd0);
        hz.FETCH_use_rs1 = 1'b0;

        // Fill to MAX_OUTSTANDING, then overflow
        for (int i = 1; i <= 3; i++) begin
            hz.LL_issue = 1'b1;
            hz.LL_issue_rd = 5'(i);
            tick();
        end
        hz.LL_issue = 1'b0;
        #1 chk("busy_at3", 32'(hz.LL_busy), 32'd0);
        hz.LL_issue = 1'b1;
        hz.LL_issue_rd = 5'd4;
        tick();
        hz.LL_issue = 1'b0;
        #1 chk("busy_at4", 32'(hz.LL_busy), 32'd1);
        hz.FETCH_ll = 1'b1;
        hz.FETCH_rd = 5'd10;
        #1 chk("busy_ll_stall", 32'(hz.FETCH_stall), 32'd1);
        hz.FETCH_ll = 1'b0;
        hz.FETCH_rd = 5'd0;
        hz.LL_issue = 1'b1;
        hz.LL_issue_rd = 5'd11;
        tick();
        hz.LL_issue = 1'b0;
        #1 chk("ovf_err", 32'(hz.SB_err), 32'd1);
        chk("ovf_busy", 32'(hz.LL_busy), 32'd1);
        hz.LL_done = 1'b1;
        hz.LL_done_rd = 5'd1;
        tick();
        hz.LL_done = 1'b0;
        #1 chk("ovf_count_held", 32'(hz.LL_busy), 32'd0);
        chk("err_sticky", 32'(hz.SB_err), 32'd1);

        // Reset with x3 pending
        rst_n = 1'b0;
        #1 chk("mid_rst_err", 32'(hz.SB_err), 32'd0);
        chk("mid_rst_busy", 32'(hz.LL_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        hz.FETCH_rs1 = 5'd3;
        hz.FETCH_use_rs1 = 1'b1;
        #1 chk("mid_rst_pending", 32'(hz.FETCH_stall), 32'd0);
        hz.FETCH_use_rs1 = 1'b0;
        hz.LL_done = 1'b1;
        hz.LL_done_rd = 5'd3;
        tick();
        hz.LL_done = 1'b0;
        #1 chk("done_unpending_err", 32'(hz.SB_err), 32'd1);

        // x0 issue/done ignored
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        hz.LL_issue = 1'b1;
        hz.LL_issue_rd = 5'd0;
        tick();
        hz.LL_issue = 1'b0;
        hz.LL_done = 1'b1;
        hz.LL_done_rd = 5'd0;
        tick();
        hz.LL_done = 1'b0;
        #1 chk("x0_no_err", 32'(hz.SB_err), 32'd0);
        chk("x0_no_count", 32'(hz.LL_busy), 32'd0);

        // Flush shadow, FLUSH_CYCLES=3
        hz.BRA = 1'b1;
        #1 chk("bra_c0", 32'(hz.EXEC_flush), 32'd1);
        tick();
        hz.BRA = 1'b0;
        #1 chk("bra_c1", 32'(hz.EXEC_flush), 32'd1);
        tick();
        #1 chk("bra_c2", 32'(hz.EXEC_flush), 32'd1);
        tick();
        #1 chk("bra_c3", 32'(hz.EXEC_flush), 32'd0);
        hz.BRA = 1'b1;
        #1 chk("reload_c0", 32'(hz.EXEC_flush), 32'd1);
        tick();
        hz.BRA = 1'b0;
        hz.JMP = 1'b1;
        #1 chk("reload_c1", 32'(hz.EXEC_flush), 32'd1);
        tick();
        hz.JMP = 1'b0;
        #1 chk("reload_c2", 32'(hz.EXEC_flush), 32'd1);
        tick();
        #1 chk("reload_c3", 32'(hz.EXEC_flush), 32'd1);
        tick();
        #1 chk("reload_c4", 32'(hz.EXEC_flush), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
